// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Holds the 4-bit opcode constants and the control FSM state encoding.
// The RTL and the testbench both import this package.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply / divide datapath.
// One shared accumulator (acc_q), one shift register (sr_q), the latched
// B operand (op_q) and an iteration counter (cnt_q).
//   multiply: radix-2 shift-add; acc:sr ends as {hi, lo}
//   divide  : restoring; sr ends as quotient, acc as remainder
// Ports:
//   clk, rst_n    clock, async active-low reset (clears the counter)
//   load_i        capture a_i / b_i and restart the counter
//   step_i        perform one iteration this cycle
//   div_i         1 = divide step, 0 = multiply step
//   a_i, b_i      operands A and B
//   last_o        the current step is the final (WIDTH-th) one
//   hi_o, lo_o    value of {acc, sr} after the current step
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   op_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH:0]     sum, shl, diff;

  always_comb begin
    acc_d = acc_q;
    sr_d  = sr_q;
    sum   = '0;
    shl   = '0;
    diff  = '0;
    if (div_i) begin
      // Shift the next dividend bit into the partial remainder, then try to
      // subtract the divisor; a set top bit of diff means it went negative.
      shl  = {acc_q, sr_q[WIDTH-1]};
      diff = shl - {1'b0, op_q};
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shl[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add B when the current multiplier LSB is set, then shift the
      // WIDTH+1-bit sum right into the acc:sr pair.
      sum  = {1'b0, acc_q} + (sr_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
      acc_d = sum[WIDTH:1];
      sr_d  = {sum[0], sr_q[WIDTH-1:1]};
    end
  end

  // Data registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q <= '0;
      sr_q  <= a_i;
      op_q  <= b_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == SHAMT_W'(WIDTH - 1));
  assign hi_o   = acc_d;
  assign lo_o   = sr_d;

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/shift ops computed inline,
// MULTU and DIVU executed over WIDTH cycles by mdu_iter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               operation request, taken only while ready=1
//   alu_cnt             4-bit opcode (alu_pkg OP_*)
//   input1, input2      operands A and B
//   shamt               shift amount for SLL/SRL/SRA (shifts B)
//   ready               a start is accepted this cycle (IDLE or DONE)
//   valid               one-cycle pulse: result/zero/hi/lo just updated
//   result, zero        ALU result and (result == 0)
//   hi, lo              MULTU product halves / DIVU remainder and quotient
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         alu_cnt,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e           state_q, state_d, accept_st;
  logic             accept, is_mul, is_div, div_by_zero;
  logic             mdu_step, mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d;

  assign accept      = ready && start;
  assign is_mul      = (alu_cnt == OP_MULTU);
  assign is_div      = (alu_cnt == OP_DIVU);
  assign div_by_zero = is_div && (input2 == '0);
  assign mdu_step    = (state_q == ST_MUL) || (state_q == ST_DIV);

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alu_cnt)
      OP_AND: alu_res = input1 & input2;
      OP_OR:  alu_res = input1 | input2;
      OP_ADD: alu_res = input1 + input2;
      OP_SLL: alu_res = input2 << shamt;
      OP_SRL: alu_res = input2 >> shamt;
      OP_SRA: alu_res = $signed(input2) >>> shamt;
      OP_SUB: alu_res = input1 - input2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_XOR: alu_res = input1 ^ input2;
      OP_NOR: alu_res = ~(input1 | input2);
      default: alu_res = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(accept && (is_mul || is_div)),
    .step_i(mdu_step),
    .div_i (state_q == ST_DIV),
    .a_i   (input1),
    .b_i   (input2),
    .last_o(mdu_last),
    .hi_o  (mdu_hi),
    .lo_o  (mdu_lo)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    if (is_mul)                     accept_st = ST_MUL;
    else if (is_div && !div_by_zero) accept_st = ST_DIV;
    else                            accept_st = ST_DONE;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = accept_st;
      ST_MUL:  if (mdu_last) state_d = ST_DONE;
      ST_DIV:  if (mdu_last) state_d = ST_DONE;
      ST_DONE: state_d = start ? accept_st : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    valid = (state_q == ST_DONE);
  end

  // Result registers: written on acceptance of a single-cycle op (including
  // DIVU by zero) or on the final MDU step, otherwise held.
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      if (div_by_zero) begin
        hi_d     = input1;
        lo_d     = '1;
        result_d = '1;
        zero_d   = 1'b0;
      end else if (!is_mul && !is_div) begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
      end
    end else if (mdu_step && mdu_last) begin
      hi_d     = mdu_hi;
      lo_d     = mdu_lo;
      result_d = mdu_lo;
      zero_d   = (mdu_lo == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_cnt = 4'd0;
  logic [31:0] input1 = 32'd0;
  logic [31:0] input2 = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        ready, valid, zero;
  logic [31:0] result, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_cnt(alu_cnt),
    .input1(input1), .input2(input2), .shamt(shamt),
    .ready(ready), .valid(valid), .result(result), .zero(zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] res, h, l;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, b,
                                    input logic [4:0] sh, inout logic [31:0] h, l,
                                    output logic [31:0] r);
    logic [63:0] p;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: r = a + b;
      OP_SLL: r = b << sh;
      OP_SRL: r = b >> sh;
      OP_SRA: r = $signed(b) >>> sh;
      OP_SUB: r = a - b;
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
        r = l;
      end
      OP_DIVU: begin
        if (b == 0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          h = a % b;
          l = a / b;
        end
        r = l;
      end
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op at a negedge while idle; check latency, outputs and hold.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [4:0] sh, input logic [31:0] er, eh, el, input int elat);
    int n;
    check({nm, "_ready"}, ready, 1);
    start = 1'b1; alu_cnt = op; input1 = a; input2 = b; shamt = sh;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    input1 = $urandom; input2 = $urandom; shamt = 5'($urandom); alu_cnt = 4'($urandom);
    n = 1;
    while (!valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, valid, 1);
    check({nm, "_latency"}, n, elat);
    check({nm, "_result"}, result, er);
    check({nm, "_zero"}, zero, (er == 0));
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
    @(negedge clk);
    check({nm, "_valid_pulse"}, valid, 0);
    check({nm, "_hold"}, {hi, result}, {eh, er});
  endtask

  initial begin
    logic [31:0] r, mh, ml;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        seen;

    vecs[0]  = '{OP_ADD,   32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        32'h0,        32'h0,        1};
    vecs[1]  = '{OP_SLL,   32'h0,        32'h1,        5'd1,  32'h2,        32'h0,        32'h0,        1};
    vecs[2]  = '{OP_SRA,   32'h0,        32'h80000000, 5'd4,  32'hF8000000, 32'h0,        32'h0,        1};
    vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h1,        32'hFFFFFFFE, 32'h1,        33};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        5'd0,  32'd14,       32'd2,        32'd14,       33};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd0,        5'd0,  32'hFFFFFFFF, 32'd100,      32'hFFFFFFFF, 1};
    vecs[6]  = '{OP_SUB,   32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 32'd100,      32'hFFFFFFFF, 1};
    vecs[7]  = '{OP_SLT,   32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        32'd100,      32'hFFFFFFFF, 1};
    vecs[8]  = '{OP_SLT,   32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        32'd100,      32'hFFFFFFFF, 1};
    vecs[9]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'd100,      32'hFFFFFFFF, 1};
    vecs[10] = '{OP_OR,    32'h0F0F0000, 32'h000000F0, 5'd0,  32'h0F0F00F0, 32'd100,      32'hFFFFFFFF, 1};
    vecs[11] = '{OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 32'd100,      32'hFFFFFFFF, 1};
    vecs[12] = '{OP_NOR,   32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 32'd100,      32'hFFFFFFFF, 1};
    vecs[13] = '{OP_SRL,   32'h0,        32'h80000000, 5'd31, 32'h1,        32'd100,      32'hFFFFFFFF, 1};
    vecs[14] = '{4'b1111,  32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h0,        32'd100,      32'hFFFFFFFF, 1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", ready, 1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
            vecs[i].res, vecs[i].h, vecs[i].l, vecs[i].lat);
    end
    mdl_hi = 32'd100;
    mdl_lo = 32'hFFFFFFFF;

    // Randomized ops against the reference model
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? OP_MULTU : OP_DIVU;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      sh = 5'($urandom);
      ref_model(op, a, b, sh, mdl_hi, mdl_lo, r);
      do_op($sformatf("rnd%0d_op%0h", k, op), op, a, b, sh, r, mdl_hi, mdl_lo,
            (op == OP_MULTU || (op == OP_DIVU && b != 0)) ? 33 : 1);
    end

    // Start pulses during MULTU are ignored; ADD issued in DONE is back-to-back
    a = 32'd12345; b = 32'd6789;
    ref_model(OP_MULTU, a, b, 5'd0, mdl_hi, mdl_lo, r);
    start = 1'b1; alu_cnt = OP_MULTU; input1 = a; input2 = b;
    @(posedge clk);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (ready || valid) seen = 1'b1;
      start = i[0]; alu_cnt = OP_ADD; input1 = $urandom; input2 = $urandom;
      @(negedge clk);
    end
    check("busy_ready_low", seen, 0);
    check("b2b_mul_valid", valid, 1);
    check("b2b_mul_result", result, r);
    check("b2b_mul_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    mh = mdl_hi; ml = mdl_lo;
    start = 1'b1; alu_cnt = OP_ADD; input1 = 32'd3; input2 = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_add_valid", valid, 1);
    check("b2b_add_result", result, 32'd7);
    check("b2b_add_hilo", {hi, lo}, {mh, ml});
    @(negedge clk);
    check("b2b_idle", valid, 0);

    // Asynchronous reset in the middle of a DIVU
    start = 1'b1; alu_cnt = OP_DIVU; input1 = 32'd1000; input2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_zero", zero, 1);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(negedge clk);
    check("arst_ready", ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (valid) seen = 1'b1;
      @(negedge clk);
    end
    check("arst_no_valid", seen, 0);
    check("arst_hold", {result, hi, lo} == 96'd0, 1);
    do_op("post_rst_add", OP_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 32'd0, 32'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHAMT_W, default 5: shift-amount width; it SHALL equal log2(WIDTH).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  operation request; sampled only while ready=1.
REQ-006 alu_cnt  in  4  opcode (see REQ-012).
REQ-007 input1, input2  in  WIDTH each  operands A and B; captured when start is accepted.
REQ-008 shamt  in  SHAMT_W  shift amount; captured when start is accepted.
REQ-009 ready  out  1  block can accept start this cycle.
REQ-010 valid  out  1  single-cycle pulse: result, zero, hi and lo are updated and valid.
REQ-011 result  out  WIDTH;  zero  out  1;  hi, lo  out  WIDTH each.

Function
REQ-012 Opcodes:
- 0000 AND; 0001 OR; 0010 ADD; 0011 SLL B by shamt; 0100 SRL B; 0101 SRA B; 0110 SUB A-B; 0111 SLT (signed A<B gives 1, else 0); 1010 XOR; 1100 NOR.
- 1000 MULTU: unsigned A*B, {hi,lo}.
- 1001 DIVU: unsigned; lo=A/B, hi=A%B.
- All other codes: result 0.
REQ-013 ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
REQ-014 FSM states are IDLE, MUL, DIV, DONE; ready=1 in IDLE and in DONE only.
REQ-015 Transitions when start is accepted:
- single-cycle opcode -> DONE;
- MULTU -> MUL;
- DIVU with B!=0 -> DIV;
- DIVU with B=0 -> DONE.
REQ-016 MUL runs a radix-2 shift-add and DIV a restoring divide, each for exactly WIDTH cycles, then goes to DONE.
REQ-017 DONE: valid=1 for one cycle. Next state is IDLE if start=0, or per REQ-015 if start=1 (back-to-back ops).
REQ-018 Latency from the accepting edge to the valid cycle: 1 cycle for single-cycle ops and DIVU-by-zero; WIDTH+1 cycles for MULTU and DIVU.
REQ-019 For MULTU and DIVU, result SHALL equal the new lo.
REQ-020 For all other opcodes, hi and lo hold their previous values.
REQ-021 DIVU by zero: lo = all ones, hi = A.
REQ-022 zero = (result == 0); it updates only together with result.
REQ-023 result, zero, hi and lo hold their values between valid pulses.
REQ-024 start while ready=0 is ignored: no queuing and no effect on the operation in flight.
REQ-025 Operand inputs may change freely after acceptance without affecting the operation in flight.

Reset
REQ-026 rst_n low SHALL force asynchronously, at any time including mid-MUL/DIV:
- state = IDLE; valid = 0;
- result = 0, zero = 1, hi = 0, lo = 0;
- iteration counter = 0.
REQ-027 After rst_n is released, ready=1 on the first clock; any operation in flight is discarded.

Structure
REQ-028 Opcode constants and FSM state encodings SHALL live in a shared package (alu_pkg) used by the decoder and the benches.
REQ-029 The iterative multiply/divide datapath SHALL be a single sub-module, mdu_iter (shared accumulator, shift register and counter), controlled by the top FSM.
REQ-030 The combinational single-cycle ALU SHALL remain inline in the top module.

Verification (WIDTH=32)
REQ-031 ADD: A=0xFFFFFFFF, B=1 -> valid 1 cycle later, result=0, zero=1.
REQ-032 SLL: B=1, shamt=1 -> result=2; SRA: B=0x80000000, shamt=4 -> result=0xF8000000.
REQ-033 MULTU: A=B=0xFFFFFFFF -> valid 33 cycles later, hi=0xFFFFFFFE, lo=0x00000001, result=1.
REQ-034 DIVU: A=100, B=7 -> lo=14, hi=2 after 33 cycles; DIVU with B=0 -> lo=0xFFFFFFFF, hi=100 after 1 cycle.
REQ-035 Pulse start repeatedly during MULTU -> ignored, ready=0 throughout; then issue ADD in the DONE cycle -> its valid arrives on the next cycle.
REQ-036 Assert rst_n low at cycle 10 of a DIVU -> outputs go to reset values immediately, ready=1 after release, no valid pulse for the aborted op.
